// File: rtl/note_event_tracker_if.sv
// Note-event bus: f0 strobe and note vector in, debounced note and event pulses out.
interface note_event_tracker_if;
    logic       note_valid;
    logic [4:0] note_in;
    logic [4:0] stable_note;
    logic       note_on;
    logic       note_off;
    logic [7:0] event_count;

    modport master (
        output note_valid, note_in,
        input  stable_note, note_on, note_off, event_count
    );

    modport slave (
        input  note_valid, note_in,
        output stable_note, note_on, note_off, event_count
    );
endinterface

// File: rtl/note_event_tracker.sv
// Debounces the per-estimate note vector into a committed note, emits on/off pulses,
// counts onsets and forces silence when estimates stop arriving.
module note_event_tracker #(
    parameter int STABLE_COUNT    = 3,
    parameter int SILENCE_TIMEOUT = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    note_event_tracker_if.slave  bus
);
    localparam int          TW     = $clog2(SILENCE_TIMEOUT + 1);
    localparam logic [3:0]  SC_W   = 4'(STABLE_COUNT);
    localparam logic [TW-1:0] T_MAX  = TW'(SILENCE_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(SILENCE_TIMEOUT - 1);

    typedef enum logic {SILENT, SOUNDING} state_t;

    state_t        state_q, state_d;
    logic [4:0]    stable_note_q, stable_note_d;
    logic [4:0]    candidate_q, candidate_d;
    logic [3:0]    match_cnt_q, match_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          note_on_q, note_on_d;
    logic          note_off_q, note_off_d;
    logic [7:0]    event_count_q, event_count_d;
    logic [4:0]    note_clean;

    // More than one bit set is ambiguous and counts as silence.
    assign note_clean = ((bus.note_in & (bus.note_in - 5'd1)) == 5'd0) ? bus.note_in : 5'd0;

    always_comb begin
        state_d       = state_q;
        stable_note_d = stable_note_q;
        candidate_d   = candidate_q;
        match_cnt_d   = match_cnt_q;
        timer_d       = timer_q;
        note_on_d     = 1'b0;
        note_off_d    = 1'b0;

        if (bus.note_valid) begin
            // A strobe always beats a timeout landing on the same edge.
            timer_d = '0;
            if (note_clean == candidate_q) begin
                match_cnt_d = (match_cnt_q >= SC_W) ? SC_W : match_cnt_q + 4'd1;
            end else begin
                candidate_d = note_clean;
                match_cnt_d = 4'd1;
            end
            if (match_cnt_d == SC_W && note_clean != stable_note_q) begin
                stable_note_d = note_clean;
                note_on_d     = (note_clean != 5'd0);
                note_off_d    = (state_q == SOUNDING);
                state_d       = (note_clean != 5'd0) ? SOUNDING : SILENT;
            end
        end else if (timer_q != T_MAX) begin
            timer_d = timer_q + TW'(1);
            if (timer_q == T_LAST) begin
                stable_note_d = 5'd0;
                candidate_d   = 5'd0;
                match_cnt_d   = 4'd0;
                note_off_d    = (state_q == SOUNDING);
                state_d       = SILENT;
            end
        end

        event_count_d = event_count_q + {7'd0, note_on_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SILENT;
            stable_note_q <= 5'd0;
            candidate_q   <= 5'd0;
            match_cnt_q   <= 4'd0;
            timer_q       <= '0;
            note_on_q     <= 1'b0;
            note_off_q    <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            stable_note_q <= stable_note_d;
            candidate_q   <= candidate_d;
            match_cnt_q   <= match_cnt_d;
            timer_q       <= timer_d;
            note_on_q     <= note_on_d;
            note_off_q    <= note_off_d;
            event_count_q <= event_count_d;
        end
    end

    assign bus.stable_note = stable_note_q;
    assign bus.note_on     = note_on_q;
    assign bus.note_off    = note_off_q;
    assign bus.event_count = event_count_q;
endmodule

// File: tb/tb_note_event_tracker.sv
// Scoreboarded bench: a history-based reference model predicts pulse events, a monitor
// pops and compares them; directed scenarios add fixed-value checks.
module tb_note_event_tracker;
    localparam int SC = 3;
    localparam int T  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_event_tracker_if bus ();

    note_event_tracker #(.STABLE_COUNT(SC), .SILENCE_TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         stamp;
        logic       on;
        logic       off;
        logic [4:0] st;
        logic [7:0] cnt;
    } ev_t;

    ev_t        evq[$];
    logic [4:0] hist[$];
    logic [4:0] m_stable = 5'd0;
    logic [7:0] m_count  = 8'd0;
    int         m_idle   = 0;
    int         edge_cnt = 0;
    int         n_cmp    = 0;
    int         n_fail   = 0;

    function automatic logic [4:0] sanitize(logic [4:0] v);
        return ($countones(v) <= 1) ? v : 5'd0;
    endfunction

    // Reference: commit when the last SC strobes since reset/silence are equal and new.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            hist.delete();
            m_stable = 5'd0;
            m_count  = 8'd0;
            m_idle   = 0;
        end else if (bus.note_valid) begin
            logic [4:0] n;
            bit         same;
            n = sanitize(bus.note_in);
            m_idle = 0;
            hist.push_back(n);
            if (hist.size() > SC) void'(hist.pop_front());
            same = (hist.size() == SC);
            foreach (hist[k]) if (hist[k] != n) same = 0;
            if (same && n != m_stable) begin
                ev_t e;
                e.on  = (n != 5'd0);
                e.off = (m_stable != 5'd0);
                if (e.on) m_count = m_count + 8'd1;
                m_stable = n;
                e.stamp = edge_cnt;
                e.st    = n;
                e.cnt   = m_count;
                evq.push_back(e);
            end
        end else if (m_idle < T) begin
            m_idle++;
            if (m_idle == T) begin
                hist.delete();
                if (m_stable != 5'd0) begin
                    ev_t e;
                    e.stamp = edge_cnt;
                    e.on    = 1'b0;
                    e.off   = 1'b1;
                    e.st    = 5'd0;
                    e.cnt   = m_count;
                    evq.push_back(e);
                end
                m_stable = 5'd0;
            end
        end
    end

    // Monitor: every DUT pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (bus.note_on || bus.note_off) begin
            n_cmp++;
            if (evq.size() == 0 || evq[0].stamp != edge_cnt) begin
                n_fail++;
                $display("FAIL unexpected_pulse edge=%0d on=%0b off=%0b st=%b, required no pulse",
                         edge_cnt, bus.note_on, bus.note_off, bus.stable_note);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if (bus.note_on !== e.on || bus.note_off !== e.off ||
                    bus.stable_note !== e.st || bus.event_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL event edge=%0d got on=%0b off=%0b st=%b cnt=%0d, required on=%0b off=%0b st=%b cnt=%0d",
                             edge_cnt, bus.note_on, bus.note_off, bus.stable_note, bus.event_count,
                             e.on, e.off, e.st, e.cnt);
                end
            end
        end
        while (evq.size() > 0 && evq[0].stamp <= edge_cnt) begin
            ev_t e;
            e = evq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed_pulse edge=%0d got none, required on=%0b off=%0b st=%b cnt=%0d",
                     e.stamp, e.on, e.off, e.st, e.cnt);
        end
    end

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle(logic [4:0] v, logic valid);
        @(negedge clk);
        bus.note_valid = valid;
        bus.note_in    = valid ? v : 5'($urandom);
    endtask

    task automatic strobe(logic [4:0] v);
        drive_cycle(v, 1'b1);
        drive_cycle(5'd0, 1'b0);
    endtask

    task automatic idle(int k);
        repeat (k) drive_cycle(5'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.note_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all(string name, int st, int on, int off, int cnt);
        $display("check %s: st=%b on=%0b off=%0b cnt=%0d", name,
                 bus.stable_note, bus.note_on, bus.note_off, bus.event_count);
        chk({name, "_stable"}, bus.stable_note, st);
        chk({name, "_on"}, bus.note_on, on);
        chk({name, "_off"}, bus.note_off, off);
        chk({name, "_count"}, bus.event_count, cnt);
    endtask

    initial begin
        logic [4:0] last;
        bus.note_valid = 1'b0;
        bus.note_in    = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all("reset_init", 0, 0, 0, 0);

        // Mid-run reset with a note sounding.
        repeat (3) strobe(5'b10000);
        chk_all("pre_reset", 5'b10000, 1, 0, 1);
        idle(10);
        pulse_reset();
        chk_all("reset_mid", 0, 0, 0, 0);

        // Onset after three spaced strobes.
        strobe(5'b00100);
        chk_all("onset_s1", 0, 0, 0, 0);
        idle(199);
        strobe(5'b00100);
        chk_all("onset_s2", 0, 0, 0, 0);
        idle(199);
        strobe(5'b00100);
        chk_all("onset_s3", 5'b00100, 1, 0, 1);
        idle(1);
        chk_all("onset_after", 5'b00100, 0, 0, 1);

        // Glitch rejection then a clean change of note.
        strobe(5'b01000);
        strobe(5'b01000);
        strobe(5'b00100);
        strobe(5'b01000);
        strobe(5'b01000);
        chk_all("glitch_hold", 5'b00100, 0, 0, 1);
        strobe(5'b01000);
        chk_all("glitch_change", 5'b01000, 1, 1, 2);

        // Multi-hot reads as silence.
        repeat (3) strobe(5'b11000);
        chk_all("multihot", 0, 0, 1, 2);

        // Timeout forces silence exactly T cycles after the last strobe.
        repeat (3) strobe(5'b00001);
        chk_all("to_commit", 5'b00001, 1, 0, 3);
        idle(999);
        chk_all("to_before", 5'b00001, 0, 0, 3);
        idle(1);
        chk_all("to_expire", 0, 0, 1, 3);
        idle(5000);
        chk_all("to_quiet", 0, 0, 0, 3);

        // A strobe landing on the expiry edge wins.
        repeat (3) strobe(5'b00001);
        chk_all("sim_commit", 5'b00001, 1, 0, 4);
        idle(998);
        strobe(5'b00001);
        chk_all("sim_edge", 5'b00001, 0, 0, 4);
        idle(999);
        chk_all("sim_restart", 5'b00001, 0, 0, 4);
        idle(1);
        chk_all("sim_expire", 0, 0, 1, 4);

        // Onset counter wrap.
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            logic [4:0] v;
            v = 5'(1 << (i % 5));
            repeat (SC) strobe(v);
            if (i == 254) chk("wrap_255", bus.event_count, 255);
        end
        chk("wrap_0", bus.event_count, 0);

        // Randomized traffic against the reference model.
        last = 5'b00010;
        for (int it = 0; it < 1200; it++) begin
            logic [4:0] v;
            int         k;
            if ($urandom_range(0, 99) < 60) begin
                v = last;
            end else begin
                k = $urandom_range(0, 6);
                if (k < 5)       v = 5'(1 << k);
                else if (k == 5) v = 5'd0;
                else             v = 5'($urandom);
            end
            last = v;
            drive_cycle(v, 1'b1);
            if ($urandom_range(0, 99) < 2) idle(900 + $urandom_range(0, 200));
            else                           idle($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end
        idle(3);
        chk("rand_stable", bus.stable_note, m_stable);
        chk("rand_count", bus.event_count, m_count);
        chk("evq_empty", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
